hbus_arbiter: RTL and testbench

- Two-port round-robin arbiter and burst sequencer in front of the `hyperbus` leader controller.
- Each requester issues a whole burst: address, direction, beat count.
- The arbiter owns the controller's `rrq`/`wrq` hold-until-done handshake, counts beats, drops the request after the last beat, and enforces a release gap between bursts.
- A watchdog aborts bursts that stall; the abort is reported as an error to the requester.

---
 rtl/hbus_pkg.sv | 22 ++
 rtl/hbus_rr_pick.sv | 31 +++
 rtl/hbus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_hbus_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hbus_pkg.sv
// rtl/hbus_pkg.sv - shared definitions for the hbus_arbiter burst sequencer
//
// Contents: one-hot sequencer state encoding, default bus widths and the
// byte-mask width helper used to size the write mask path.
package hbus_pkg;

    localparam int HBUS_WIDTH       = 8;
    localparam int HBUS_ADDR_LENGTH = 32;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_XFER  = 4'b0100,
        ST_GAP   = 4'b1000
    } state_t;

    // One mask bit per byte of a beat; a beat is 2*width bits.
    function automatic int mask_width(input int width);
        return (2 * width + 7) / 8;
    endfunction

endpackage

// File: rtl/hbus_rr_pick.sv
// rtl/hbus_rr_pick.sv - two-way round-robin pick with last-winner register
//
// Ports:
//   clk90, rst     clock, asynchronous active-high reset
//   req_a, req_b   pending requests
//   take           commit the current pick as the new last winner
//   pick_b         1 = port B wins, 0 = port A wins (valid when a request is pending)
module hbus_rr_pick (
    input  logic clk90,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic pick_b
);

    logic last_b;

    // B wins when alone, or on a tie when A was the previous winner.
    assign pick_b = req_b & (~req_a | ~last_b);

    // Reset to "B won last" so A takes the first tie.
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (take) begin
            last_b <= pick_b;
        end
    end

endmodule

// File: rtl/hbus_arbiter.sv
// rtl/hbus_arbiter.sv - two-port round-robin burst arbiter in front of the hyperbus leader
//
// Ports:
//   clk90, rst                  clock (HyperBus clk shifted 90 deg), async active-high reset
//   a_*/b_* inputs              burst request: req, we, reg, adr, len (beats-1), wdat, mask
//   a_*/b_* outputs             gnt, wready, rvalid, rdata, done (1-cycle), err (with done on abort)
//   adr_o, dat_o, mask_o,
//   reg_space_o, wrq_o, rrq_o   controller request side (hold-until-done rrq/wrq)
//   ready_i, valid_i, dat_i     controller write-accept, read-valid and read data
module hbus_arbiter
    import hbus_pkg::*;
#(
    parameter int WIDTH       = HBUS_WIDTH,
    parameter int ADDR_LENGTH = HBUS_ADDR_LENGTH,
    parameter int LEN_W       = 8,
    parameter int GAP_COUNT   = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk90,
    input  logic                   rst,
    input  logic                   a_req,
    input  logic                   a_we,
    input  logic                   a_reg,
    input  logic [ADDR_LENGTH-1:0] a_adr,
    input  logic [LEN_W-1:0]       a_len,
    input  logic [2*WIDTH-1:0]     a_wdat,
    input  logic [1:0]             a_mask,
    output logic                   a_gnt,
    output logic                   a_wready,
    output logic                   a_rvalid,
    output logic [2*WIDTH-1:0]     a_rdata,
    output logic                   a_done,
    output logic                   a_err,
    input  logic                   b_req,
    input  logic                   b_we,
    input  logic                   b_reg,
    input  logic [ADDR_LENGTH-1:0] b_adr,
    input  logic [LEN_W-1:0]       b_len,
    input  logic [2*WIDTH-1:0]     b_wdat,
    input  logic [1:0]             b_mask,
    output logic                   b_gnt,
    output logic                   b_wready,
    output logic                   b_rvalid,
    output logic [2*WIDTH-1:0]     b_rdata,
    output logic                   b_done,
    output logic                   b_err,
    output logic [ADDR_LENGTH-1:0] adr_o,
    output logic [2*WIDTH-1:0]     dat_o,
    output logic [2:0]             mask_o,
    output logic                   reg_space_o,
    output logic                   wrq_o,
    output logic                   rrq_o,
    input  logic                   ready_i,
    input  logic                   valid_i,
    input  logic [2*WIDTH-1:0]     dat_i
);

    localparam int MW   = mask_width(WIDTH);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int GC_W = $clog2(GAP_COUNT + 1);

    state_t                 state, state_nx;
    logic                   owner_b, lat_we, lat_reg;
    logic [ADDR_LENGTH-1:0] lat_adr;
    logic [LEN_W-1:0]       lat_len;
    logic [LEN_W:0]         beats;      // one extra bit so len=all-ones never wraps
    logic [WD_W-1:0]        wdog;
    logic [GC_W-1:0]        gap_cnt;
    logic [2*WIDTH-1:0]     rdata_q;
    logic                   rvalid_q, done_q, err_q;
    logic                   any_req, take, pick_b;
    logic                   beat, last_beat, timeout, gap_end;
    logic                   gnt, wr_path;
    logic [MW-1:0]          mask_sel;

    assign any_req = a_req | b_req;
    assign take    = (state == ST_IDLE) & any_req;

    hbus_rr_pick u_pick (
        .clk90  (clk90),
        .rst    (rst),
        .req_a  (a_req),
        .req_b  (b_req),
        .take   (take),
        .pick_b (pick_b)
    );

    // A beat is a controller handshake in XFER only; ready/valid seen in
    // ISSUE or GAP (pipeline lag after the request drops) are ignored.
    assign beat      = (state == ST_XFER) & (lat_we ? ready_i : valid_i);
    assign last_beat = beat & (beats == {1'b0, lat_len});
    assign timeout   = (state == ST_XFER) & ~beat & (wdog == WD_W'(TIMEOUT - 1));
    assign gap_end   = (gap_cnt == GC_W'(GAP_COUNT - 1));

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (any_req) state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_XFER;
            ST_XFER:  if (last_beat | timeout) state_nx = ST_GAP;
            ST_GAP:   if (gap_end) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Request lines and grant are held from ISSUE through XFER and fall
    // together on GAP entry, so rrq_o/wrq_o can never be high at once.
    always_comb begin
        gnt         = 1'b0;
        wrq_o       = 1'b0;
        rrq_o       = 1'b0;
        adr_o       = '0;
        reg_space_o = 1'b0;
        if (state == ST_ISSUE || state == ST_XFER) begin
            gnt         = 1'b1;
            wrq_o       = lat_we;
            rrq_o       = ~lat_we;
            adr_o       = lat_adr;
            reg_space_o = lat_reg;
        end
    end

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            owner_b  <= 1'b0;
            lat_we   <= 1'b0;
            lat_reg  <= 1'b0;
            lat_adr  <= '0;
            lat_len  <= '0;
            beats    <= '0;
            wdog     <= '0;
            gap_cnt  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            done_q   <= last_beat | timeout;
            err_q    <= timeout;
            if (take) begin
                owner_b <= pick_b;
                lat_we  <= pick_b ? b_we  : a_we;
                lat_reg <= pick_b ? b_reg : a_reg;
                lat_adr <= pick_b ? b_adr : a_adr;
                lat_len <= pick_b ? b_len : a_len;
            end
            if (state == ST_ISSUE) begin
                beats <= '0;
                wdog  <= '0;
            end else if (beat) begin
                beats <= beats + 1'b1;
                wdog  <= '0;
            end else if (state == ST_XFER) begin
                wdog <= wdog + 1'b1;
            end
            if (beat & ~lat_we) begin
                rdata_q  <= dat_i;
                rvalid_q <= 1'b1;
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // owner_b only changes in IDLE, so it still names the right port for
    // the registered rvalid/done that land in the first GAP cycle.
    assign wr_path  = gnt & lat_we;
    assign dat_o    = wr_path ? (owner_b ? b_wdat : a_wdat) : '0;
    assign mask_sel = wr_path ? (owner_b ? b_mask : a_mask) : '0;
    assign mask_o   = {1'b0, mask_sel};

    assign a_gnt    = gnt & ~owner_b;
    assign b_gnt    = gnt & owner_b;
    assign a_wready = beat & lat_we & ~owner_b;
    assign b_wready = beat & lat_we & owner_b;
    assign a_rvalid = rvalid_q & ~owner_b;
    assign b_rvalid = rvalid_q & owner_b;
    assign a_rdata  = owner_b ? '0 : rdata_q;
    assign b_rdata  = owner_b ? rdata_q : '0;
    assign a_done   = done_q & ~owner_b;
    assign b_done   = done_q & owner_b;
    assign a_err    = err_q & ~owner_b;
    assign b_err    = err_q & owner_b;

endmodule

// File: tb/tb_hbus_arbiter.sv
// tb/tb_hbus_arbiter.sv - self-checking bench for hbus_arbiter
module tb_hbus_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk90 = 1'b0;
    logic        rst;
    logic        a_req, a_we, a_reg, b_req, b_we, b_reg;
    logic [31:0] a_adr, b_adr;
    logic [7:0]  a_len, b_len;
    logic [15:0] a_wdat, b_wdat;
    logic [1:0]  a_mask, b_mask;
    logic        a_gnt, a_wready, a_rvalid, a_done, a_err;
    logic        b_gnt, b_wready, b_rvalid, b_done, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic [31:0] adr_o;
    logic [15:0] dat_o;
    logic [2:0]  mask_o;
    logic        reg_space_o, wrq_o, rrq_o;
    logic        ready_i, valid_i;
    logic [15:0] dat_i;

    int checks = 0;
    int errors = 0;

    hbus_arbiter dut (
        .clk90(clk90), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_reg(a_reg), .a_adr(a_adr), .a_len(a_len),
        .a_wdat(a_wdat), .a_mask(a_mask), .a_gnt(a_gnt), .a_wready(a_wready),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_done(a_done), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_reg(b_reg), .b_adr(b_adr), .b_len(b_len),
        .b_wdat(b_wdat), .b_mask(b_mask), .b_gnt(b_gnt), .b_wready(b_wready),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_done(b_done), .b_err(b_err),
        .adr_o(adr_o), .dat_o(dat_o), .mask_o(mask_o), .reg_space_o(reg_space_o),
        .wrq_o(wrq_o), .rrq_o(rrq_o), .ready_i(ready_i), .valid_i(valid_i), .dat_i(dat_i)
    );

    always #5 clk90 = ~clk90;

    typedef struct {
        bit          a_req, b_req, first_b;
        bit          a_we, b_we, a_reg, b_reg;
        int          a_len, b_len;
        logic [31:0] a_adr, b_adr;
        logic [15:0] a_base, a_step, b_base, b_step;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] beat_dat(input logic [15:0] base, input logic [15:0] step, input int k);
        return 16'(base + step * 16'(k));
    endfunction

    function automatic logic any_out();
        return |{a_gnt, a_wready, a_rvalid, a_rdata, a_done, a_err,
                 b_gnt, b_wready, b_rvalid, b_rdata, b_done, b_err,
                 adr_o, dat_o, mask_o, reg_space_o, wrq_o, rrq_o};
    endfunction

    // Grant and request exclusivity, checked every cycle out of reset.
    always @(negedge clk90) begin
        #2;
        if (!rst) begin
            checks++;
            if ((a_gnt && b_gnt) || (rrq_o && wrq_o) || (a_done && b_done)) begin
                errors++;
                $display("FAIL exclusive gnt=%b%b rq=%b%b done=%b%b", a_gnt, b_gnt, rrq_o, wrq_o, a_done, b_done);
            end
        end
    end

    // Runs one burst for the expected winner while acting as the controller.
    // Entered just after a negedge with the requests already set up.
    task automatic do_burst(input string name, input bit exp_b, input bit we, input int len,
                            input logic [31:0] adr, input bit rs, input logic [15:0] base,
                            input logic [15:0] step, input bit stall);
        int cyc, k, sent, seen, req_cyc;
        bit issued, done_seen;
        cyc = 0; k = 0; sent = 0; seen = 0; req_cyc = 0;
        issued = 1'b0; done_seen = 1'b0;
        while (!done_seen && cyc < 600) begin
            @(negedge clk90);
            cyc++;
            ready_i = we && !stall;
            valid_i = 1'b0;
            if (!we && !stall && issued && rrq_o && sent <= len) begin
                valid_i = 1'b1;
                dat_i   = beat_dat(base, step, sent);
                sent++;
            end
            if (exp_b) b_wdat = beat_dat(base, step, k);
            else       a_wdat = beat_dat(base, step, k);
            #1;
            if (rrq_o || wrq_o) begin
                if (!issued) begin
                    chk({name, " gnt"}, 64'({a_gnt, b_gnt}), 64'(exp_b ? 2'b01 : 2'b10));
                    chk({name, " kind"}, 64'({wrq_o, rrq_o}), 64'(we ? 2'b10 : 2'b01));
                    chk({name, " adr"}, 64'({reg_space_o, adr_o}), 64'({rs, adr}));
                end
                issued = 1'b1;
                req_cyc++;
            end
            if (a_wready || b_wready) begin
                chk({name, " wready_port"}, 64'({a_wready, b_wready}), 64'(exp_b ? 2'b01 : 2'b10));
                chk({name, " wr_data"}, 64'({mask_o, dat_o}),
                    64'({exp_b ? 3'b010 : 3'b001, beat_dat(base, step, k)}));
                k++;
            end
            if (a_rvalid || b_rvalid) begin
                chk({name, " rvalid_port"}, 64'({a_rvalid, b_rvalid}), 64'(exp_b ? 2'b01 : 2'b10));
                chk({name, " rdata"}, 64'(exp_b ? b_rdata : a_rdata), 64'(beat_dat(base, step, seen)));
                seen++;
            end
            if (a_done || b_done) begin
                done_seen = 1'b1;
                chk({name, " done_port"}, 64'({a_done, b_done}), 64'(exp_b ? 2'b01 : 2'b10));
                chk({name, " err"}, 64'({a_err, b_err}), 64'(stall ? (exp_b ? 2'b01 : 2'b10) : 2'b00));
                chk({name, " gnt_drop"}, 64'({a_gnt, b_gnt, a_wready, b_wready, rrq_o, wrq_o}), 64'(0));
                if (exp_b) b_req = 1'b0;
                else       a_req = 1'b0;
                // Stray controller valid arriving in GAP must be dropped.
                valid_i = !we;
                dat_i   = 16'hDEAD;
            end
        end
        chk({name, " done_seen"}, 64'(done_seen), 64'(1));
        chk({name, " beats"}, 64'(we ? k : seen), 64'(stall ? 0 : len + 1));
        chk({name, " req_cycles"}, 64'(req_cyc), 64'(stall ? TIMEOUT + 1 : len + 2));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk90);
            ready_i = 1'b0;
            valid_i = 1'b0;
            #1;
            chk({name, " gap"}, 64'({rrq_o, wrq_o, a_rvalid, b_rvalid, a_done, b_done, a_wready, b_wready}), 64'(0));
        end
    endtask

    task automatic run_port(input int v, input bit pb, input bit stall);
        string nm;
        nm = $sformatf("v%0d_%s", v, pb ? "B" : "A");
        if (pb) do_burst(nm, 1'b1, vecs[v].b_we, vecs[v].b_len, vecs[v].b_adr, vecs[v].b_reg,
                         vecs[v].b_base, vecs[v].b_step, stall);
        else    do_burst(nm, 1'b0, vecs[v].a_we, vecs[v].a_len, vecs[v].a_adr, vecs[v].a_reg,
                         vecs[v].a_base, vecs[v].a_step, stall);
    endtask

    task automatic load_vec(input int v);
        a_we = vecs[v].a_we;  a_reg = vecs[v].a_reg; a_adr = vecs[v].a_adr; a_len = 8'(vecs[v].a_len);
        b_we = vecs[v].b_we;  b_reg = vecs[v].b_reg; b_adr = vecs[v].b_adr; b_len = 8'(vecs[v].b_len);
        a_req = vecs[v].a_req;
        b_req = vecs[v].b_req;
    endtask

    initial begin
        int k, cyc;
        //            a_req b_req first_b a_we  b_we  a_reg b_reg a_len b_len a_adr        b_adr        a_base    a_step    b_base    b_step
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1,   32'h10,  32'h20,  16'h0101, 16'h0101, 16'h0A0A, 16'h0101};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0,   32'h100, 32'h0,   16'h1111, 16'h1111, 16'h0000, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0,   32'h200, 32'h0,   16'hAAAA, 16'hAAAB, 16'h0000, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 255, 32'h300, 32'h400, 16'h1234, 16'h0000, 16'h0000, 16'h0001};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0,   32'h500, 32'h600, 16'h5555, 16'h0000, 16'h6666, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 4,   32'h0,   32'h700, 16'h0000, 16'h0000, 16'h7000, 16'h0011};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 3,   32'h800, 32'h900, 16'h8000, 16'h0001, 16'h9000, 16'h0001};

        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_reg = 1'b0; a_adr = '0; a_len = '0; a_wdat = '0; a_mask = 2'b01;
        b_req = 1'b0; b_we = 1'b0; b_reg = 1'b0; b_adr = '0; b_len = '0; b_wdat = '0; b_mask = 2'b10;
        ready_i = 1'b0; valid_i = 1'b0; dat_i = '0;

        @(negedge clk90);
        #1;
        chk("reset_outputs", 64'(any_out()), 64'(0));
        rst = 1'b0;
        @(negedge clk90);
        #1;
        chk("post_reset_idle", 64'(any_out()), 64'(0));

        for (int v = 0; v < 7; v++) begin
            load_vec(v);
            run_port(v, vecs[v].first_b, 1'b0);
            if (vecs[v].a_req && vecs[v].b_req) run_port(v, !vecs[v].first_b, 1'b0);
        end

        // Watchdog: A's read never gets a valid; B waits and is served after the abort.
        a_we = 1'b0; a_reg = 1'b0; a_adr = 32'hA00; a_len = 8'd3;
        b_we = 1'b0; b_reg = 1'b0; b_adr = 32'hB00; b_len = 8'd1;
        a_req = 1'b1; b_req = 1'b1;
        do_burst("timeout_A", 1'b0, 1'b0, 3, 32'hA00, 1'b0, 16'h0, 16'h0, 1'b1);
        do_burst("after_timeout_B", 1'b1, 1'b0, 1, 32'hB00, 1'b0, 16'h4242, 16'h0100, 1'b0);

        // Reset on the third beat of an 8-beat write, then a fresh burst.
        a_we = 1'b1; a_reg = 1'b0; a_adr = 32'hC00; a_len = 8'd7;
        a_req = 1'b1; ready_i = 1'b1;
        k = 0; cyc = 0;
        while (k < 2 && cyc < 20) begin
            @(negedge clk90);
            a_wdat = beat_dat(16'hC000, 16'h0001, k);
            #1;
            if (a_wready) k++;
            cyc++;
        end
        chk("midwrite_beats_before_reset", 64'(k), 64'(2));
        rst = 1'b1;
        #1;
        chk("midwrite_reset_immediate", 64'(any_out()), 64'(0));
        @(negedge clk90);
        #1;
        chk("midwrite_reset_held", 64'(any_out()), 64'(0));
        rst = 1'b0;
        do_burst("after_reset_A", 1'b0, 1'b1, 7, 32'hC00, 1'b0, 16'hC000, 16'h0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
